// File: rtl/fifo_uart_tx.sv
// Serial transmitter fed by a synchronous FIFO's registered read port.
// Frame: start, DATA_WIDTH data bits LSB first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_WIDTH    = 4,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   localparam int IDX_WIDTH = 8;
   localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
   localparam logic [IDX_WIDTH-1:0] DATA_LAST = IDX_WIDTH'(DATA_WIDTH - 1);
   localparam logic [IDX_WIDTH-1:0] STOP_LAST = IDX_WIDTH'(STOP_BITS - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ZERO  = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1'b1);

   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
      return ^d;
   endfunction

   state_t                state_r;
   logic [CNT_WIDTH-1:0]  baud_cnt_r;
   logic [IDX_WIDTH-1:0]  bit_idx_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  parity_r;
   logic                  bit_end_s;
   logic                  fetch_ok_s;
   logic [DATA_WIDTH-1:0] shift_nxt_s;

   assign bit_end_s   = (baud_cnt_r == BAUD_LAST);
   assign fetch_ok_s  = enable && !fifo_empty;
   assign shift_nxt_s = {1'b0, shift_r[DATA_WIDTH-1:1]};

   // Frame sequencer: state, baud/bit counters, shift register and every output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         baud_cnt_r <= CNT_ZERO;
         bit_idx_r  <= IDX_ZERO;
         shift_r    <= {DATA_WIDTH{1'b0}};
         parity_r   <= 1'b0;
         tx         <= 1'b1;
         fifo_r_en  <= 1'b0;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done   <= 1'b0;
         fifo_r_en <= 1'b0;
         case (state_r)
            IDLE: begin
               tx <= 1'b1;
               if (fetch_ok_s) begin
                  state_r   <= FETCH;
                  fifo_r_en <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               state_r <= LOAD;
            end
            // Read data is valid only now; the start bit goes out on this same edge.
            LOAD: begin
               shift_r    <= fifo_data;
               parity_r   <= even_parity(fifo_data);
               baud_cnt_r <= CNT_ZERO;
               state_r    <= START;
               tx         <= 1'b0;
            end
            START: begin
               if (bit_end_s) begin
                  baud_cnt_r <= CNT_ZERO;
                  bit_idx_r  <= IDX_ZERO;
                  state_r    <= DATA;
                  tx         <= shift_r[0];
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  baud_cnt_r <= CNT_ZERO;
                  shift_r    <= shift_nxt_s;
                  if (bit_idx_r == DATA_LAST) begin
                     bit_idx_r <= IDX_ZERO;
                     if (PARITY_EN != 0) begin
                        state_r <= PARITY;
                        tx      <= parity_r;
                     end else begin
                        state_r <= STOP;
                        tx      <= 1'b1;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_ONE;
                     tx        <= shift_nxt_s[0];
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_ONE;
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  baud_cnt_r <= CNT_ZERO;
                  bit_idx_r  <= IDX_ZERO;
                  state_r    <= STOP;
                  tx         <= 1'b1;
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_ONE;
               end
            end
            // bit_idx_r is reused here to count stop bits.
            STOP: begin
               tx <= 1'b1;
               if (bit_end_s) begin
                  baud_cnt_r <= CNT_ZERO;
                  if (bit_idx_r == STOP_LAST) begin
                     bit_idx_r <= IDX_ZERO;
                     tx_done   <= 1'b1;
                     if (fetch_ok_s) begin
                        state_r   <= FETCH;
                        fifo_r_en <= 1'b1;
                     end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_ONE;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r    <= IDLE;
               baud_cnt_r <= CNT_ZERO;
               bit_idx_r  <= IDX_ZERO;
               tx         <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / 1 stop, even parity / 2 stops),
// each fed by a small FIFO model, checked against hand-computed bit sequences.
module tb_fifo_uart_tx;

   logic clk;
   logic rst;
   logic en0, en1;
   logic empty0, empty1;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic r_en0, r_en1, tx0, tx1, busy0, busy1, done0, done1;

   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
   int pop0 = 0, pop1 = 0, bad_pop = 0;
   int total = 0, passed = 0;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [0:11] bits;
      int         nslots;
   } vec_t;
   vec_t vecs [5];

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(2), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0), .fifo_data(data0),
      .fifo_r_en(r_en0), .tx(tx0), .busy(busy0), .tx_done(done0));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(2), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1), .fifo_data(data1),
      .fifo_r_en(r_en1), .tx(tx1), .busy(busy1), .tx_done(done1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign empty0 = (wr0 == rd0);
   assign empty1 = (wr1 == rd1);

   // FIFO models: registered read data, one word per pop strobe
   always @(posedge clk) begin
      if (r_en0) begin
         pop0 <= pop0 + 1;
         if (empty0) bad_pop <= bad_pop + 1;
         else begin
            data0 <= mem0[rd0 % 16];
            rd0   <= rd0 + 1;
         end
      end
      if (r_en1) begin
         pop1 <= pop1 + 1;
         if (empty1) bad_pop <= bad_pop + 1;
         else begin
            data1 <= mem1[rd1 % 16];
            rd1   <= rd1 + 1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic g_tx(input int s);
      return (s == 1) ? tx1 : tx0;
   endfunction
   function automatic logic g_ren(input int s);
      return (s == 1) ? r_en1 : r_en0;
   endfunction
   function automatic logic g_busy(input int s);
      return (s == 1) ? busy1 : busy0;
   endfunction
   function automatic logic g_done(input int s);
      return (s == 1) ? done1 : done0;
   endfunction
   function automatic int g_pop(input int s);
      return (s == 1) ? pop1 : pop0;
   endfunction

   task automatic set_en(input int s, input logic v);
      if (s == 1) en1 = v;
      else en0 = v;
   endtask

   task automatic push(input int s, input logic [7:0] d);
      if (s == 1) begin
         mem1[wr1 % 16] = d;
         wr1 = wr1 + 1;
      end else begin
         mem0[wr0 % 16] = d;
         wr0 = wr0 + 1;
      end
   endtask

   task automatic wait_fetch(input int s);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick;
         if (g_ren(s) === 1'b1) found = 1'b1;
      end
      chk("fetch_seen", {31'd0, found}, 32'd1);
   endtask

   // Entered while sampling the FETCH cycle; leaves while sampling the cycle after the last stop cycle.
   task automatic check_frame(input int s, input logic [0:11] bits, input int nslots,
                              input logic nxt, input int drop_slot);
      tick;
      chk("load_tx_high", {31'd0, g_tx(s)}, 32'd1);
      chk("load_no_pop", {31'd0, g_ren(s)}, 32'd0);
      for (int k = 0; k < nslots; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (k == drop_slot && c == 0) set_en(s, 1'b0);
            tick;
            chk($sformatf("tx_slot%0d_cyc%0d", k, c), {31'd0, g_tx(s)}, {31'd0, bits[k]});
            if (c == 0) begin
               chk("busy_in_frame", {31'd0, g_busy(s)}, 32'd1);
               chk("no_early_done", {31'd0, g_done(s)}, 32'd0);
            end
         end
      end
      tick;
      chk("tx_done_pulse", {31'd0, g_done(s)}, 32'd1);
      chk("tx_idle_after", {31'd0, g_tx(s)}, 32'd1);
      chk("busy_after", {31'd0, g_busy(s)}, {31'd0, nxt});
      chk("next_fetch", {31'd0, g_ren(s)}, {31'd0, nxt});
   endtask

   initial begin
      int base;
      vecs[0] = '{sel: 0, data: 8'hA5, bits: 12'b0101_0010_1100, nslots: 10};
      vecs[1] = '{sel: 0, data: 8'h3C, bits: 12'b0001_1110_0100, nslots: 10};
      vecs[2] = '{sel: 1, data: 8'h07, bits: 12'b0111_0000_0111, nslots: 12};
      vecs[3] = '{sel: 1, data: 8'h5A, bits: 12'b0010_1101_0011, nslots: 12};
      vecs[4] = '{sel: 1, data: 8'h00, bits: 12'b0000_0000_0011, nslots: 12};

      // Reset with a word waiting and enable high: nothing may move
      rst = 1'b1;
      en0 = 1'b1;
      en1 = 1'b0;
      push(0, 8'hEE);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_tx", {31'd0, tx0}, 32'd1);
         chk("rst_ren", {31'd0, r_en0}, 32'd0);
         chk("rst_busy", {31'd0, busy0}, 32'd0);
         chk("rst_done", {31'd0, done0}, 32'd0);
      end
      chk("rst_tx1", {31'd0, tx1}, 32'd1);
      chk("rst_no_pop", pop0, 32'd0);
      en0 = 1'b0;
      wr0 = rd0;
      rst = 1'b0;
      tick;
      chk("idle_busy", {31'd0, busy0}, 32'd0);
      chk("idle_tx", {31'd0, tx0}, 32'd1);

      // Single frames from the vector table
      for (int v = 0; v < 5; v++) begin
         base = g_pop(vecs[v].sel);
         push(vecs[v].sel, vecs[v].data);
         set_en(vecs[v].sel, 1'b1);
         wait_fetch(vecs[v].sel);
         check_frame(vecs[v].sel, vecs[v].bits, vecs[v].nslots, 1'b0, -1);
         tick;
         chk("done_one_cycle", {31'd0, g_done(vecs[v].sel)}, 32'd0);
         chk("one_pop", g_pop(vecs[v].sel) - base, 32'd1);
         set_en(vecs[v].sel, 1'b0);
      end

      // Back-to-back: three words, FETCH follows the final stop cycle directly
      base = pop0;
      push(0, 8'h01);
      push(0, 8'h80);
      push(0, 8'hFF);
      en0 = 1'b1;
      wait_fetch(0);
      check_frame(0, 12'b0100_0000_0100, 10, 1'b1, -1);
      check_frame(0, 12'b0000_0000_1100, 10, 1'b1, -1);
      check_frame(0, 12'b0111_1111_1100, 10, 1'b0, -1);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("b2b_no_pop_empty", {31'd0, r_en0}, 32'd0);
      end
      chk("b2b_pops", pop0 - base, 32'd3);

      // Enable dropped during data bit 3 with another word queued
      base = pop0;
      push(0, 8'h3C);
      push(0, 8'h55);
      en0 = 1'b1;
      wait_fetch(0);
      check_frame(0, 12'b0001_1110_0100, 10, 1'b0, 4);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk("drop_no_fetch", {31'd0, r_en0}, 32'd0);
         chk("drop_idle", {31'd0, busy0}, 32'd0);
      end
      chk("drop_pops", pop0 - base, 32'd1);

      // Reset during data bit 5 of the queued 0x55, then a clean fresh frame
      base = pop0;
      en0 = 1'b1;
      wait_fetch(0);
      tick;
      for (int i = 0; i < 25; i++) tick;
      chk("pre_rst_bit5", {31'd0, tx0}, 32'd0);
      chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
      rst = 1'b1;
      tick;
      chk("mid_rst_tx", {31'd0, tx0}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
      chk("mid_rst_done", {31'd0, done0}, 32'd0);
      chk("mid_rst_ren", {31'd0, r_en0}, 32'd0);
      rst = 1'b0;
      push(0, 8'h3C);
      wait_fetch(0);
      check_frame(0, 12'b0001_1110_0100, 10, 1'b0, -1);
      tick;
      chk("post_rst_pops", pop0 - base, 32'd2);
      chk("never_pop_empty", bad_pop, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
